// File: rtl/narnet_seq_ctrl.sv
// Sequencer in front of the NARNet inference core: open-loop per-sample inference
// or H-step closed-loop forecasting, with result backpressure and a core watchdog.
//
// state | meaning
// IDLE  | waiting for an input sample (open-loop) or a start request (closed-loop)
// ISSUE | one-cycle sample strobe to the core, watchdog cleared
// WAIT  | waiting for the core result flag to rise; watchdog counting
// HOLD  | result presented downstream until accepted

module narnet_seq_ctrl #(
    parameter int HORIZON_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 start,
    input  logic [HORIZON_W-1:0] horizon,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    output logic                 core_en,
    output logic                 core_rst,
    output logic                 core_x_ready,
    output logic [7:0]           core_x,
    input  logic [7:0]           core_y,
    input  logic                 core_out_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          result_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0]          WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [HORIZON_W-1:0] ONE_H   = 1;

    state_t               state;
    logic [7:0]           x_reg;
    logic [7:0]           fb;
    logic [HORIZON_W-1:0] h_reg;
    logic [HORIZON_W-1:0] step;
    logic                 cl_run;
    logic                 out_rdy_prev;
    logic [15:0]          wd;
    logic                 rise;
    logic                 last_step;
    logic                 wd_fire;

    assign core_en   = enable;
    assign core_x    = x_reg;
    assign busy      = (state != IDLE);
    assign rise      = core_out_ready & ~out_rdy_prev;
    assign last_step = cl_run & (step == h_reg - ONE_H);
    // A result edge in the same cycle as the last watchdog tick still wins.
    assign wd_fire   = (state == WAIT) & ~rise & (wd == WD_LAST);

    assign s_ready      = enable & ~rst & (state == IDLE) & ~mode;
    assign core_x_ready = enable & ~rst & (state == ISSUE);
    assign core_rst     = enable & ~rst & wd_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_reg        <= 8'd0;
            fb           <= 8'd0;
            h_reg        <= '0;
            step         <= '0;
            cl_run       <= 1'b0;
            out_rdy_prev <= 1'b0;
            wd           <= 16'd0;
            m_valid      <= 1'b0;
            m_data       <= 8'd0;
            m_last       <= 1'b0;
            timeout_err  <= 1'b0;
            result_cnt   <= 16'd0;
        end else if (enable) begin
            out_rdy_prev <= core_out_ready;
            case (state)
                IDLE: begin
                    if (mode && start) begin
                        h_reg  <= horizon;
                        step   <= '0;
                        cl_run <= 1'b1;
                        if (horizon != '0) begin
                            x_reg <= fb;
                            state <= ISSUE;
                        end
                    end else if (!mode && s_valid) begin
                        x_reg  <= s_data;
                        cl_run <= 1'b0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= 16'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (rise) begin
                        m_data  <= core_y;
                        fb      <= core_y;
                        m_valid <= 1'b1;
                        m_last  <= last_step;
                        state   <= HOLD;
                    end else if (wd_fire) begin
                        timeout_err <= 1'b1;
                        cl_run      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        result_cnt <= result_cnt + 16'd1;
                        if (cl_run && !last_step) begin
                            step  <= step + ONE_H;
                            x_reg <= fb;
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_narnet_seq_ctrl.sv
// Directed bench for narnet_seq_ctrl: a long-timeout instance with a behavioural core,
// plus a TIMEOUT=10 instance whose core result flag is driven by hand.

module tb_narnet_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  horizon = 8'd0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic [7:0]  core_y = 8'd0;
    logic        core_out_ready = 1'b0;
    logic        wd_out_ready = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready, core_en, core_rst, core_x_ready, m_valid, m_last, busy, timeout_err;
    logic [7:0]  core_x, m_data;
    logic [15:0] result_cnt;

    logic        w_s_ready, w_core_en, w_core_rst, w_core_x_ready, w_m_valid, w_m_last, w_busy;
    logic        w_timeout_err;
    logic [7:0]  w_core_x, w_m_data;
    logic [15:0] w_result_cnt;

    narnet_seq_ctrl #(.HORIZON_W(8), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .start(start), .horizon(horizon),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_en(core_en), .core_rst(core_rst), .core_x_ready(core_x_ready), .core_x(core_x),
        .core_y(core_y), .core_out_ready(core_out_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .timeout_err(timeout_err), .result_cnt(result_cnt)
    );

    narnet_seq_ctrl #(.HORIZON_W(8), .TIMEOUT(10)) u_wd (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .start(start), .horizon(horizon),
        .s_valid(s_valid), .s_ready(w_s_ready), .s_data(s_data),
        .core_en(w_core_en), .core_rst(w_core_rst), .core_x_ready(w_core_x_ready),
        .core_x(w_core_x), .core_y(core_y), .core_out_ready(wd_out_ready),
        .m_valid(w_m_valid), .m_ready(m_ready), .m_data(w_m_data), .m_last(w_m_last),
        .busy(w_busy), .timeout_err(w_timeout_err), .result_cnt(w_result_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // core model controls and observations
    logic       core_op = 1'b0;   // 0: y = x ^ 0x32, 1: y = x + 1
    int         core_delay = 5;
    int         strobe_cnt = 0;
    int         strobe_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] last_x = 8'd0;
    int         w_strobe_cyc = 0;
    int         w_rst_cyc = 0;
    int         w_rst_cnt = 0;

    int acc_cyc = 0;
    int mv_cyc = 0;
    int hs_cyc = 0;

    typedef struct {
        logic [7:0] x;
        int         dly;
        int         hold;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // behavioural core for the main instance
    initial begin
        forever begin
            @(negedge clk);
            if (core_x_ready) begin
                strobe_cnt++;
                strobe_cyc = cyc;
                last_x = core_x;
                repeat (core_delay) @(negedge clk);
                core_y = core_op ? last_x + 8'd1 : last_x ^ 8'h32;
                core_out_ready = 1'b1;
                rise_cyc = cyc;
                @(negedge clk);
                core_out_ready = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (w_core_x_ready) w_strobe_cyc = cyc;
            if (w_core_rst) begin
                w_rst_cyc = cyc;
                w_rst_cnt++;
            end
        end
    end

    task automatic send_sample(input logic [7:0] x);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        s_data = x;
        s_valid = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("sample_accepted", {31'd0, ok}, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_valid) begin
                got = 1'b1;
                mv_cyc = cyc;
                break;
            end
        end
        check("m_valid_arrives", {31'd0, got}, 32'd1);
    endtask

    task automatic accept_result;
        m_ready = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wait_wd_rst(input int n_before, input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (w_rst_cnt > n_before) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wd_core_rst_fires", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int  n0;
        int  nr;
        logic ok;

        vecs[0] = '{x: 8'h18, dly: 30, hold: 0,  y: 8'h2A};
        vecs[1] = '{x: 8'h00, dly: 4,  hold: 0,  y: 8'h32};
        vecs[2] = '{x: 8'h7F, dly: 1,  hold: 0,  y: 8'h4D};
        vecs[3] = '{x: 8'h80, dly: 7,  hold: 0,  y: 8'hB2};
        vecs[4] = '{x: 8'hFF, dly: 2,  hold: 0,  y: 8'hCD};
        vecs[5] = '{x: 8'h18, dly: 3,  hold: 20, y: 8'h2A};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result_cnt", {16'd0, result_cnt}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_core_x", {24'd0, core_x}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_core_en", {31'd0, core_en}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", {31'd0, s_ready}, 32'd1);

        // open-loop vectors
        for (int i = 0; i < 6; i++) begin
            core_delay = vecs[i].dly;
            n0 = strobe_cnt;
            send_sample(vecs[i].x);
            wait_mvalid(200);
            check($sformatf("ol_strobes[%0d]", i), strobe_cnt - n0, 1);
            check($sformatf("ol_core_x[%0d]", i), {24'd0, last_x}, {24'd0, vecs[i].x});
            check($sformatf("ol_strobe_lat[%0d]", i), strobe_cyc - acc_cyc, 1);
            check($sformatf("ol_mvalid_lat[%0d]", i), mv_cyc - rise_cyc, 1);
            check($sformatf("ol_m_data[%0d]", i), {24'd0, m_data}, {24'd0, vecs[i].y});
            check($sformatf("ol_m_last[%0d]", i), {31'd0, m_last}, 32'd0);
            if (vecs[i].hold > 0) begin
                ok = 1'b1;
                for (int j = 0; j < vecs[i].hold; j++) begin
                    @(negedge clk);
                    if (m_data !== vecs[i].y || m_valid !== 1'b1 || s_ready !== 1'b0) ok = 1'b0;
                end
                check("bp_stable", {31'd0, ok}, 32'd1);
                check("bp_no_strobe", strobe_cnt - n0, 1);
            end
            accept_result;
            check($sformatf("ol_result_cnt[%0d]", i), {16'd0, result_cnt}, i + 1);
            check($sformatf("ol_m_valid_clr[%0d]", i), {31'd0, m_valid}, 32'd0);
            check($sformatf("ol_s_ready_back[%0d]", i), {31'd0, s_ready}, 32'd1);
        end

        // closed-loop, H = 3, fb starts at 0x2A
        core_op = 1'b1;
        core_delay = 3;
        n0 = strobe_cnt;
        mode = 1'b1;
        @(negedge clk);
        check("cl_s_ready_mode1", {31'd0, s_ready}, 32'd0);
        horizon = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_mvalid(100);
            check($sformatf("cl_core_x[%0d]", k), {24'd0, last_x}, 32'h2A + k);
            check($sformatf("cl_m_data[%0d]", k), {24'd0, m_data}, 32'h2B + k);
            check($sformatf("cl_m_last[%0d]", k), {31'd0, m_last}, (k == 2) ? 32'd1 : 32'd0);
            check($sformatf("cl_s_ready[%0d]", k), {31'd0, s_ready}, 32'd0);
            if (k > 0) check($sformatf("cl_reissue_lat[%0d]", k), strobe_cyc - hs_cyc, 1);
            accept_result;
        end
        check("cl_strobes", strobe_cnt - n0, 3);
        check("cl_busy_end", {31'd0, busy}, 32'd0);
        check("cl_m_last_clr", {31'd0, m_last}, 32'd0);
        check("cl_result_cnt", {16'd0, result_cnt}, 32'd9);

        // horizon = 0 is a no-op
        n0 = strobe_cnt;
        horizon = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = (busy === 1'b0);
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || m_valid !== 1'b0) ok = 1'b0;
        end
        check("h0_idle", {31'd0, ok}, 32'd1);
        check("h0_no_strobe", strobe_cnt - n0, 0);

        // watchdog on the TIMEOUT=10 instance
        mode = 1'b0;
        core_op = 1'b0;
        core_delay = 3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("wd_err_after_rst", {31'd0, w_timeout_err}, 32'd0);
        nr = w_rst_cnt;
        send_sample(8'h11);
        wait_mvalid(50);
        accept_result;
        wait_wd_rst(nr, 30);
        check("wd_rst_delay", w_rst_cyc - w_strobe_cyc, 10);
        repeat (3) @(negedge clk);
        check("wd_rst_width", w_rst_cnt - nr, 1);
        check("wd_err_set", {31'd0, w_timeout_err}, 32'd1);
        check("wd_back_idle", {31'd0, w_busy}, 32'd0);
        check("wd_no_result", {31'd0, w_m_valid}, 32'd0);

        // next sample after a timeout is processed normally
        send_sample(8'h05);
        repeat (4) @(negedge clk);
        wd_out_ready = 1'b1;
        @(negedge clk);
        wd_out_ready = 1'b0;
        check("wd_recover_m_valid", {31'd0, w_m_valid}, 32'd1);
        check("wd_recover_m_data", {24'd0, w_m_data}, 32'h37);
        check("main_m_valid_pair", {31'd0, m_valid}, 32'd1);
        accept_result;
        check("wd_recover_cnt", {16'd0, w_result_cnt}, 32'd1);
        check("wd_err_sticky", {31'd0, w_timeout_err}, 32'd1);

        // freeze during WAIT, then reset during HOLD
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wd_err_cleared", {31'd0, w_timeout_err}, 32'd0);
        core_delay = 12;
        nr = w_rst_cnt;
        send_sample(8'h10);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b1 || w_busy !== 1'b1 || core_en !== 1'b0 || m_valid !== 1'b0
                || w_core_rst !== 1'b0 || core_x_ready !== 1'b0) ok = 1'b0;
        end
        check("frz_hold", {31'd0, ok}, 32'd1);
        enable = 1'b1;
        wait_mvalid(50);
        check("frz_m_data", {24'd0, m_data}, 32'h22);
        check("frz_mvalid_lat", mv_cyc - rise_cyc, 1);
        accept_result;
        check("frz_result_cnt", {16'd0, result_cnt}, 32'd1);
        wait_wd_rst(nr, 30);
        check("frz_wd_delay", w_rst_cyc - w_strobe_cyc, 15);

        core_delay = 3;
        nr = w_rst_cnt;
        send_sample(8'h20);
        wait_mvalid(50);
        check("hold_m_data", {24'd0, m_data}, 32'h12);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("hrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("hrst_busy", {31'd0, busy}, 32'd0);
        check("hrst_result_cnt", {16'd0, result_cnt}, 32'd0);
        check("hrst_m_data", {24'd0, m_data}, 32'd0);
        check("hrst_no_core_rst", w_rst_cnt - nr, 0);
        rst = 1'b0;
        @(negedge clk);
        check("hrst_s_ready", {31'd0, s_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/narnet_seq_ctrl.md
Name: narnet_seq_ctrl

Overview:
- Sequencer in front of the NARNet inference core. Accepts input samples on a valid/ready stream and issues one core inference per sample (open-loop mode).
- Alternatively runs an H-step closed-loop forecast, feeding each prediction back as the next core input (closed-loop mode).
- Returns results on an output stream with backpressure. Watchdogs the core and resets it on a hang.

Parameters:
- HORIZON_W, 8, width of closed-loop horizon count.
- TIMEOUT, 255, maximum core cycles allowed in WAIT before the watchdog fires (1..2^16-1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  global advance; low freezes all controller state
- mode  in  1  0 = open-loop, 1 = closed-loop; sampled only in IDLE
- start  in  1  closed-loop run request pulse
- horizon  in  HORIZON_W  closed-loop step count, latched with start
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid & s_ready
- s_data  in  8  signed S8.6 input sample
- core_en  out  1  core enable
- core_rst  out  1  core reset pulse
- core_x_ready  out  1  one-cycle sample strobe to core
- core_x  out  8  sample to core
- core_y  in  8  core prediction
- core_out_ready  in  1  core result flag
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid & m_ready
- m_data  out  8  signed prediction
- m_last  out  1  marks final step of a closed-loop run
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag
- result_cnt  out  16  wrapping count of results accepted downstream

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0 except core_en = enable.
  - Feedback register fb = 0, step counter 0, timeout_err 0, result_cnt 0.
- core_en = enable (combinational). When enable = 0:
  - State, counters and registers hold.
  - core_x_ready, core_rst forced 0.
  - m_valid/m_data hold their values.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - s_ready = (mode == 0).
  - If mode = 1 and start = 1: latch H = horizon, step = 0.
    - If H = 0, stay in IDLE (no-op).
    - Otherwise x_reg = fb, go to ISSUE.
  - Else if mode = 0 and s_valid = 1: x_reg = s_data, go to ISSUE.
  - start has priority. s_valid is ignored (s_ready = 0) whenever mode = 1.
- ISSUE (1 cycle):
  - core_x_ready = 1, core_x = x_reg.
  - Clear watchdog counter, go to WAIT.
  - core_x holds x_reg in every state.
- WAIT:
  - Watchdog increments each enabled cycle.
  - On the rising edge of core_out_ready (registered previous value): m_data = core_y, fb = core_y, m_valid = 1, m_last = (mode latched 1 and step == H-1), go to HOLD.
  - If the watchdog reaches TIMEOUT first:
    - core_rst = 1 for one cycle, timeout_err = 1.
    - The sample is dropped and any closed-loop run is aborted.
    - Go to IDLE. No m_valid.
- HOLD:
  - m_valid stays high until m_ready. On acceptance: m_valid = 0, m_last = 0, result_cnt += 1.
  - Closed-loop with step < H-1: step += 1, x_reg = fb, go to ISSUE.
  - Otherwise go to IDLE.
  - m_data is stable while m_valid = 1.
- Latency (enable held high):
  - Sample accept at cycle t, core_x_ready at t+1.
  - m_valid is asserted one cycle after the core_out_ready rising edge.
  - Next ISSUE is issued in the cycle after the m_ready handshake.
- Only one inference is outstanding at any time. The controller never strobes core_x_ready outside ISSUE.
- timeout_err clears only on rst. result_cnt wraps 0xFFFF -> 0.
- rst mid-run: next cycle is IDLE with all outputs at reset values. core_rst is not pulsed by rst; the core has its own reset.

Test Plan:
- Open-loop single: mode = 0, s_data = 0x18 (core model returns 0x2A after 30 cycles) -> one core_x_ready pulse with core_x = 0x18; m_valid with m_data = 0x2A; m_last = 0; result_cnt = 1.
- Backpressure: hold m_ready = 0 for 20 cycles after m_valid -> m_data stable at its value, s_ready = 0, no second core_x_ready; release -> s_ready = 1 next cycle.
- Closed-loop: prior fb = 0x2A, mode = 1, start with horizon = 3; core echoes x+1 -> core_x sequence 0x2A, 0x2B, 0x2C; m_data 0x2B, 0x2C, 0x2D; m_last only on 0x2D; s_ready = 0 throughout.
- horizon = 0 with start -> no core_x_ready, no m_valid, busy stays 0.
- Watchdog: TIMEOUT = 10, core never asserts out_ready -> core_rst pulses exactly 10 cycles after ISSUE; timeout_err = 1 until rst; return to IDLE; next sample is processed normally.
- Freeze/reset: drop enable for 5 cycles during WAIT -> watchdog and state hold; later assert rst during HOLD -> m_valid = 0, state IDLE, result_cnt = 0.
